dual_issue_ctrl: RTL and testbench
==================================

Name: dual_issue_ctrl

Overview:
Decode-stage issue controller for the dual-issue pipeline. It sits between the IF/ID register and the ID/EX register. Each cycle it decides whether slot 1, slot 2, both, or neither of the decoded instruction pair may enter ID/EX. It splits dependent or structurally conflicting pairs over two cycles, inserts load-use bubbles, and maintains saturating hazard counters.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pair_valid  in  1  IF/ID holds a valid instruction pair
flush  in  1  branch/jump redirect; discard current pair
rs1_1, rs2_1, rd_1  in  5 each  slot 1 register fields
rs1_2, rs2_2, rd_2  in  5 each  slot 2 register fields
regwrite_1, memread_1, memwrite_1, Alusrc_1  in  1 each  slot 1 control unit outputs
regwrite_2, memread_2, memwrite_2, Alusrc_2  in  1 each  slot 2 control unit outputs
ex_memread1, ex_memread2  in  1 each  memread of ID/EX lanes 1 and 2
ex_rd1, ex_rd2  in  5 each  rd of ID/EX lanes 1 and 2
issue1, issue2  out  1 each  lane may enter ID/EX; 0 forces all lane controls to 0 (bubble)
stall_fetch  out  1  hold PC and IF/ID
split_active  out  1  state is SPLIT
split_count  out  CNT_W  pairs split since reset
loaduse_count  out  CNT_W  load-use bubble cycles since reset

Behaviour:
- Reset (reset=0, asynchronous): state=PAIR, both counters=0.
  - While reset is asserted: issue1=issue2=stall_fetch=split_active=0.
- Outputs issue1, issue2, stall_fetch and split_active are combinational from the state and the current inputs. This is zero-latency, so ID/EX captures the decision at the same edge.
- Source-use rules:
  - rs1 is always used.
  - rs2 is used when Alusrc_x=0 or memwrite_x=1.
  - A register x0 match never counts as a dependency.
- Hazard terms:
  - raw: regwrite_1 & rd_1!=0 & (rd_1==rs1_2 | (rs2 used by slot 2 & rd_1==rs2_2)).
  - waw: regwrite_1 & regwrite_2 & rd_1==rd_2 & rd_1!=0.
  - mem: (memread_1|memwrite_1) & (memread_2|memwrite_2). There is a single data-memory port.
  - lu(slot): for either ID/EX lane with ex_memread=1 and ex_rd!=0, ex_rd matches any used source of that slot.
- Priority, highest first: reset > flush > load-use > split logic.
- State PAIR:
  - flush=1 or pair_valid=0: issue1=issue2=0, stall_fetch=0, stay PAIR.
  - lu(slot1)|lu(slot2): issue1=issue2=0, stall_fetch=1, stay PAIR, loaduse_count+1.
  - raw|waw|mem: issue1=1, issue2=0, stall_fetch=1, go to SPLIT, split_count+1.
  - Otherwise: issue1=issue2=1, stall_fetch=0, stay PAIR.
- State SPLIT (IF/ID still holds the same pair; slot 1 has already issued):
  - flush=1: issue1=issue2=0, stall_fetch=0, go to PAIR.
  - lu(slot2): issue1=issue2=0, stall_fetch=1, stay SPLIT, loaduse_count+1. The hazard is evaluated against slot 2 only.
  - Otherwise: issue1=0, issue2=1, stall_fetch=0, go to PAIR.
- split_active=1 exactly when state=SPLIT.
- Counters saturate at all-ones and never wrap.
- Simultaneous flush and hazard: flush wins, and no counter increments.
- Reset mid-SPLIT: slot 2 is dropped, and the pair is refetched after redirect by the front end.

Decomposition:
- Shared package holds:
  - State encoding localparams: ST_PAIR=1'b0, ST_SPLIT=1'b1.
  - REG_ZERO=5'd0.
- One natural sub-module: hazard_cmp. It is combinational and compares one slot's rs1/rs2/uses-rs2 against an (rd, valid) pair, returning a match. It is instantiated for the raw check and the four load-use checks.
- State register and counters stay in dual_issue_ctrl.

Test Plan:
- Independent pair: slot1 add x1 (rd=1), slot2 add x5 reading x2,x3 -> issue1=issue2=1, stall_fetch=0, counters stay 0.
- Intra-pair RAW: slot1 rd=3 regwrite, slot2 rs1=3 -> cycle 0 issue1=1/issue2=0/stall=1/split_active=0; cycle 1 issue1=0/issue2=1/stall=0/split_active=1; split_count=1.
- Load-use: ex_memread1=1, ex_rd1=7, slot2 rs2=7 with Alusrc_2=0 -> one cycle issue1=issue2=0, stall=1, loaduse_count=1; next cycle (ex_memread1=0) both issue.
- Dual memory op: slot1 lw, slot2 sw, no register overlap -> split over 2 cycles; split_count=1.
- Flush in SPLIT: after a RAW split, assert flush in cycle 1 -> issue1=issue2=0, stall=0, state PAIR, and no counter change that cycle.
- Async reset mid-SPLIT plus x0 rules:
  - Drop reset low between edges -> outputs go to 0 immediately, counters reset to 0, state PAIR.
  - slot1 rd=0 with slot2 rs1=0 -> no split.
  - Force 2^CNT_W-1 splits with CNT_W=4 -> split_count holds at 15.

Source files
------------

// File: rtl/dual_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dual_issue_ctrl_pkg
// Shared definitions for the dual-issue decode-stage issue controller:
// state encoding, the x0 register index and the source-use helper.
// ---------------------------------------------------------------------------
package dual_issue_ctrl_pkg;

  localparam logic [0:0] ST_PAIR  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // rs2 is a real source for R-type ops (immediate not selected) and for
  // stores, where rs2 supplies the data to write.
  function automatic logic rs2_used(input logic alusrc, input logic memwrite);
    return (!alusrc) || memwrite;
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_hazard_cmp.sv
// ---------------------------------------------------------------------------
// hazard_cmp
// Combinational source/destination comparator. Flags a match when a valid
// producer (rd, rd_vld) writes a register that one instruction slot reads.
// A producer targeting x0 never matches.
//
// Ports:
//   rs1      in  5  slot source 1 (always used)
//   rs2      in  5  slot source 2
//   use_rs2  in  1  slot actually reads rs2
//   rd       in  5  producer destination
//   rd_vld   in  1  producer writes rd (regwrite or memread)
//   match    out 1  dependency detected
// ---------------------------------------------------------------------------
module hazard_cmp
  import dual_issue_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       rd_vld,
  output logic       match
);

  assign match = rd_vld && (rd != REG_ZERO) &&
                 ((rd == rs1) || (use_rs2 && (rd == rs2)));

endmodule

// File: rtl/dual_issue_ctrl.sv
// ---------------------------------------------------------------------------
// dual_issue_ctrl
// Decode-stage issue controller for a dual-issue pipeline. Decides each
// cycle which slot(s) of the IF/ID pair may enter ID/EX, splitting
// dependent / memory-conflicting pairs over two cycles, inserting load-use
// bubbles and counting both events with saturating counters.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   pair_valid, flush     IF/ID pair valid; redirect discards the pair
//   rs1_x, rs2_x, rd_x    slot register fields (x = 1, 2)
//   regwrite_x, memread_x, memwrite_x, Alusrc_x   slot controls
//   ex_memread1/2, ex_rd1/2                       ID/EX lane load info
//   issue1, issue2        lane may enter ID/EX (0 = bubble)
//   stall_fetch           hold PC and IF/ID
//   split_active          controller is issuing slot 2 of a split pair
//   split_count           pairs split since reset (saturating)
//   loaduse_count         load-use bubble cycles since reset (saturating)
//
// Decisions are combinational so ID/EX captures them at the same edge.
// ---------------------------------------------------------------------------
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pair_valid,
  input  logic             flush,
  input  logic [4:0]       rs1_1,
  input  logic [4:0]       rs2_1,
  input  logic [4:0]       rd_1,
  input  logic [4:0]       rs1_2,
  input  logic [4:0]       rs2_2,
  input  logic [4:0]       rd_2,
  input  logic             regwrite_1,
  input  logic             memread_1,
  input  logic             memwrite_1,
  input  logic             Alusrc_1,
  input  logic             regwrite_2,
  input  logic             memread_2,
  input  logic             memwrite_2,
  input  logic             Alusrc_2,
  input  logic             ex_memread1,
  input  logic             ex_memread2,
  input  logic [4:0]       ex_rd1,
  input  logic [4:0]       ex_rd2,
  output logic             issue1,
  output logic             issue2,
  output logic             stall_fetch,
  output logic             split_active,
  output logic [CNT_W-1:0] split_count,
  output logic [CNT_W-1:0] loaduse_count
);

  logic             state_q, state_d;
  logic [CNT_W-1:0] split_count_q, split_count_d;
  logic [CNT_W-1:0] loaduse_count_q, loaduse_count_d;

  logic use_rs2_1, use_rs2_2;
  logic raw, waw, mem;
  logic lu_1a, lu_1b, lu_2a, lu_2b;
  logic lu_s1, lu_s2;
  logic iss1, iss2, stall, split_inc, lu_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (en && (v != {CNT_W{1'b1}})) ? v + one : v;
  endfunction

  assign use_rs2_1 = rs2_used(Alusrc_1, memwrite_1);
  assign use_rs2_2 = rs2_used(Alusrc_2, memwrite_2);

  // Intra-pair RAW: slot 1 produces what slot 2 reads.
  hazard_cmp u_raw (
    .rs1(rs1_2), .rs2(rs2_2), .use_rs2(use_rs2_2),
    .rd(rd_1), .rd_vld(regwrite_1), .match(raw)
  );

  // Load-use: each slot against each ID/EX lane holding a load.
  hazard_cmp u_lu_1a (
    .rs1(rs1_1), .rs2(rs2_1), .use_rs2(use_rs2_1),
    .rd(ex_rd1), .rd_vld(ex_memread1), .match(lu_1a)
  );
  hazard_cmp u_lu_1b (
    .rs1(rs1_1), .rs2(rs2_1), .use_rs2(use_rs2_1),
    .rd(ex_rd2), .rd_vld(ex_memread2), .match(lu_1b)
  );
  hazard_cmp u_lu_2a (
    .rs1(rs1_2), .rs2(rs2_2), .use_rs2(use_rs2_2),
    .rd(ex_rd1), .rd_vld(ex_memread1), .match(lu_2a)
  );
  hazard_cmp u_lu_2b (
    .rs1(rs1_2), .rs2(rs2_2), .use_rs2(use_rs2_2),
    .rd(ex_rd2), .rd_vld(ex_memread2), .match(lu_2b)
  );

  assign lu_s1 = lu_1a || lu_1b;
  assign lu_s2 = lu_2a || lu_2b;

  assign waw = regwrite_1 && regwrite_2 && (rd_1 == rd_2) && (rd_1 != REG_ZERO);
  // Only one data-memory port: two memory ops cannot share a cycle.
  assign mem = (memread_1 || memwrite_1) && (memread_2 || memwrite_2);

  always_comb begin
    state_d   = state_q;
    iss1      = 1'b0;
    iss2      = 1'b0;
    stall     = 1'b0;
    split_inc = 1'b0;
    lu_inc    = 1'b0;
    if (state_q == ST_PAIR) begin
      if (pair_valid && !flush) begin
        if (lu_s1 || lu_s2) begin
          stall  = 1'b1;
          lu_inc = 1'b1;
        end else if (raw || waw || mem) begin
          iss1      = 1'b1;
          stall     = 1'b1;
          split_inc = 1'b1;
          state_d   = ST_SPLIT;
        end else begin
          iss1 = 1'b1;
          iss2 = 1'b1;
        end
      end
    end else begin
      // Slot 1 already issued; only slot 2's sources matter now.
      if (flush) begin
        state_d = ST_PAIR;
      end else if (lu_s2) begin
        stall  = 1'b1;
        lu_inc = 1'b1;
      end else begin
        iss2    = 1'b1;
        state_d = ST_PAIR;
      end
    end
  end

  always_comb begin
    split_count_d   = sat_inc(split_count_q, split_inc);
    loaduse_count_d = sat_inc(loaduse_count_q, lu_inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_PAIR;
      split_count_q   <= '0;
      loaduse_count_q <= '0;
    end else begin
      state_q         <= state_d;
      split_count_q   <= split_count_d;
      loaduse_count_q <= loaduse_count_d;
    end
  end

  // Outputs are forced low while reset is held, independent of inputs.
  assign issue1        = reset && iss1;
  assign issue2        = reset && iss2;
  assign stall_fetch   = reset && stall;
  assign split_active  = reset && (state_q == ST_SPLIT);
  assign split_count   = split_count_q;
  assign loaduse_count = loaduse_count_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
module tb_dual_issue_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic pair_valid, flush;
  logic [4:0] rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
  logic regwrite_1, memread_1, memwrite_1, Alusrc_1;
  logic regwrite_2, memread_2, memwrite_2, Alusrc_2;
  logic ex_memread1, ex_memread2;
  logic [4:0] ex_rd1, ex_rd2;
  logic issue1, issue2, stall_fetch, split_active;
  logic [CNT_W-1:0] split_count, loaduse_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pair_valid(pair_valid), .flush(flush),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
    .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2),
    .regwrite_1(regwrite_1), .memread_1(memread_1), .memwrite_1(memwrite_1), .Alusrc_1(Alusrc_1),
    .regwrite_2(regwrite_2), .memread_2(memread_2), .memwrite_2(memwrite_2), .Alusrc_2(Alusrc_2),
    .ex_memread1(ex_memread1), .ex_memread2(ex_memread2), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .issue1(issue1), .issue2(issue2), .stall_fetch(stall_fetch), .split_active(split_active),
    .split_count(split_count), .loaduse_count(loaduse_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic i1, input logic i2,
                         input logic st, input logic sa);
    chk({tag, ".issue1"}, 32'(issue1), 32'(i1));
    chk({tag, ".issue2"}, 32'(issue2), 32'(i2));
    chk({tag, ".stall"}, 32'(stall_fetch), 32'(st));
    chk({tag, ".split_active"}, 32'(split_active), 32'(sa));
  endtask

  task automatic chk_cnt(input string tag, input int sc, input int lc);
    chk({tag, ".split_count"}, 32'(split_count), 32'(sc));
    chk({tag, ".loaduse_count"}, 32'(loaduse_count), 32'(lc));
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pair_valid = 1'b1; flush = 1'b0;
    rs1_1 = 5'd0; rs2_1 = 5'd0; rd_1 = 5'd0;
    rs1_2 = 5'd0; rs2_2 = 5'd0; rd_2 = 5'd0;
    regwrite_1 = 1'b0; memread_1 = 1'b0; memwrite_1 = 1'b0; Alusrc_1 = 1'b1;
    regwrite_2 = 1'b0; memread_2 = 1'b0; memwrite_2 = 1'b0; Alusrc_2 = 1'b1;
    ex_memread1 = 1'b0; ex_memread2 = 1'b0; ex_rd1 = 5'd0; ex_rd2 = 5'd0;
  endtask

  // Independent pair: addi x1,x2,imm ; add x5,x2,x3
  task automatic set_indep();
    clear_inputs();
    rd_1 = 5'd1; rs1_1 = 5'd2; regwrite_1 = 1'b1; Alusrc_1 = 1'b1;
    rd_2 = 5'd5; rs1_2 = 5'd2; rs2_2 = 5'd3; regwrite_2 = 1'b1; Alusrc_2 = 1'b0;
  endtask

  // RAW pair: addi x3,x4,imm ; addi x6,x3,imm
  task automatic set_raw();
    clear_inputs();
    rd_1 = 5'd3; rs1_1 = 5'd4; regwrite_1 = 1'b1;
    rd_2 = 5'd6; rs1_2 = 5'd3; regwrite_2 = 1'b1;
  endtask

  initial begin
    clear_inputs();
    set_indep();
    reset = 1'b0;
    #2;
    chk_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("in_reset", 0, 0);
    step();
    reset = 1'b1;
    #1;

    // Independent pair issues together.
    chk_out("indep", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_cnt("indep", 0, 0);

    // Intra-pair RAW split.
    set_raw();
    #1;
    chk_out("raw_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("raw_c1", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnt("raw_c1", 1, 0);
    step();
    chk("raw_back_pair", 32'(split_active), 32'd0);

    // Load-use on slot 2 rs2 (R-type).
    clear_inputs();
    rd_1 = 5'd1; rs1_1 = 5'd2; regwrite_1 = 1'b1;
    rd_2 = 5'd8; rs1_2 = 5'd4; rs2_2 = 5'd7; Alusrc_2 = 1'b0; regwrite_2 = 1'b1;
    ex_memread1 = 1'b1; ex_rd1 = 5'd7;
    #1;
    chk_out("lu", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_cnt("lu", 1, 1);
    ex_memread1 = 1'b0;
    #1;
    chk_out("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // Dual memory op: lw x8,0(x9) ; sw x11,0(x10)
    clear_inputs();
    rd_1 = 5'd8; rs1_1 = 5'd9; regwrite_1 = 1'b1; memread_1 = 1'b1;
    rs1_2 = 5'd10; rs2_2 = 5'd11; memwrite_2 = 1'b1;
    #1;
    chk_out("mem_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    // A load in ID/EX matching only slot 1's source must not stall slot 2.
    ex_memread1 = 1'b1; ex_rd1 = 5'd9;
    #1;
    chk_out("mem_c1", 1'b0, 1'b1, 1'b0, 1'b1);
    chk_cnt("mem_c1", 2, 1);
    step();
    chk_cnt("mem_done", 2, 1);

    // Flush while in SPLIT.
    set_raw();
    step();
    chk_cnt("fl_split", 3, 1);
    flush = 1'b1;
    #1;
    chk_out("fl_split", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("fl_state", 32'(split_active), 32'd0);
    chk_cnt("fl_after", 3, 1);

    // Flush together with a RAW hazard in PAIR: flush wins, no count.
    set_raw();
    flush = 1'b1;
    #1;
    chk_out("fl_pair", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_cnt("fl_pair", 3, 1);

    // pair_valid low: nothing issues.
    set_raw();
    pair_valid = 1'b0;
    #1;
    chk_out("novalid", 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // x0 rules: slot1 writes x0, slot2 reads x0; a load to x0 in ID/EX.
    clear_inputs();
    rd_1 = 5'd0; regwrite_1 = 1'b1; rs1_1 = 5'd0;
    rs1_2 = 5'd0; rd_2 = 5'd0; regwrite_2 = 1'b1;
    ex_memread1 = 1'b1; ex_rd1 = 5'd0;
    #1;
    chk_out("x0", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_cnt("x0", 3, 1);

    // WAW on same rd splits.
    clear_inputs();
    rd_1 = 5'd12; rs1_1 = 5'd13; regwrite_1 = 1'b1;
    rd_2 = 5'd12; rs1_2 = 5'd14; regwrite_2 = 1'b1;
    #1;
    chk_out("waw_c0", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk_cnt("waw", 4, 1);

    // Load-use on slot 2 while in SPLIT.
    set_raw();
    step();
    ex_memread2 = 1'b1; ex_rd2 = 5'd3;
    #1;
    chk_out("lu_split", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_cnt("lu_split", 5, 2);
    ex_memread2 = 1'b0;
    #1;
    chk_out("lu_split_go", 1'b0, 1'b1, 1'b0, 1'b1);
    step();

    // Async reset in the middle of a SPLIT.
    set_raw();
    step();
    chk("pre_rst_split", 32'(split_active), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt("mid_rst", 0, 0);
    #1;
    reset = 1'b1;
    set_indep();
    #1;
    chk_out("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // Saturation: 17 splits with a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      set_raw();
      step();
      step();
    end
    chk_cnt("sat", 15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
